// File: rtl/tc0100scn_rom_bridge.sv
// tc0100scn_rom_bridge
// Bridges the TC0100SCN tile-graphics ROM port (toggle req/ack, 32-bit
// longwords) onto the shared 16-bit SDRAM port. Each longword is fetched as
// two consecutive beats. A one-entry hit register holds the most recently
// fetched longword. A one-deep pending slot captures a request that arrives
// while a fetch is in flight, so the two fetches per tilemap slot overlap.
module tc0100scn_rom_bridge #(
  parameter logic [26:0] ROM_BASE = 27'h0,
  parameter bit          HIT_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,

  // TC0100SCN side
  input  logic [20:0] rom_address,
  input  logic        rom_req,
  output logic        rom_ack,
  output logic [31:0] rom_data,

  // SDRAM arbiter side
  output logic [26:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic        mem_valid,
  input  logic [15:0] mem_data,

  // Control and status
  input  logic        inval,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BEAT0 = 2'd2,
    BEAT1 = 2'd3
  } state_t;

  state_t      state;

  // Request edge tracking
  logic        req_seen;
  logic        new_req;

  // One-deep pending slot
  logic        pending;
  logic [20:0] pend_addr;
  logic        pend_tag;

  // Request currently being fetched from SDRAM
  logic [20:0] cur_addr;
  logic        cur_tag;
  logic [15:0] beat_hi;
  logic        inval_seen;

  // Last-fetch hit register
  logic        hit_valid;
  logic [20:0] hit_addr;
  logic [31:0] hit_data;

  // Request selected for service when the bridge is idle
  logic        svc_valid;
  logic [20:0] svc_addr;
  logic        svc_tag;
  logic        svc_hit;

  // A toggle of rom_req relative to the last value seen is a new request.
  assign new_req = (rom_req != req_seen);

  // Pick the request to serve when idle: the pending slot is older than
  // anything arriving on the port this cycle, so it goes first.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value held and no latch is inferred.
    svc_valid = 1'b0;
    svc_addr  = rom_address;
    svc_tag   = rom_req;
    svc_hit   = 1'b0;
    if (pending) begin
      svc_valid = 1'b1;
      svc_addr  = pend_addr;
      svc_tag   = pend_tag;
    end else if (new_req) begin
      svc_valid = 1'b1;
    end
    // An invalidate in the same cycle suppresses the hit. The ROM contents
    // behind hit_data may already be changing.
    svc_hit = HIT_EN && hit_valid && (svc_addr == hit_addr) && !inval;
  end

  // Main sequencer: request detection, pending slot, SDRAM handshake,
  // beat assembly, hit register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the hit and pending data registers are cleared along with their
      // valid flags. Nothing reads them while invalid, but clearing them keeps
      // the outputs deterministic and avoids X from simulation start.
      state      <= IDLE;
      req_seen   <= 1'b0;
      pending    <= 1'b0;
      pend_addr  <= '0;
      pend_tag   <= 1'b0;
      cur_addr   <= '0;
      cur_tag    <= 1'b0;
      beat_hi    <= '0;
      inval_seen <= 1'b0;
      hit_valid  <= 1'b0;
      hit_addr   <= '0;
      hit_data   <= '0;
      rom_ack    <= 1'b0;
      rom_data   <= '0;
      mem_addr   <= '0;
      mem_req    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments. Later statements
      // in this block still see the pre-edge values, and where two branches
      // assign the same register the last assignment wins.
      if (new_req) begin
        req_seen <= rom_req;
      end

      unique case (state)
        IDLE: begin
          // Consume the pending slot. A request arriving in the same cycle
          // takes its place.
          if (pending) begin
            pending <= new_req;
            if (new_req) begin
              pend_addr <= rom_address;
              pend_tag  <= rom_req;
            end
          end

          if (svc_valid) begin
            if (svc_hit) begin
              rom_data <= hit_data;
              rom_ack  <= svc_tag;
            end else begin
              state      <= REQ;
              mem_req    <= 1'b1;
              mem_addr   <= ROM_BASE + {6'b0, svc_addr};
              cur_addr   <= svc_addr;
              cur_tag    <= svc_tag;
              inval_seen <= inval;
            end
          end
        end

        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= BEAT0;
          end
        end

        BEAT0: begin
          if (mem_valid) begin
            beat_hi <= mem_data;
            state   <= BEAT1;
          end
        end

        BEAT1: begin
          if (mem_valid) begin
            rom_data <= {beat_hi, mem_data};
            rom_ack  <= cur_tag;
            hit_addr <= cur_addr;
            hit_data <= {beat_hi, mem_data};
            // Data fetched across an invalidate may be stale, so it is
            // returned but not cached.
            if (HIT_EN && !inval_seen && !inval) begin
              hit_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // A request arriving mid-fetch waits in the pending slot. If the slot is
      // already full, the older request is dropped and the loss is flagged.
      if (state != IDLE && new_req) begin
        if (pending) begin
          overrun <= 1'b1;
        end
        pending   <= 1'b1;
        pend_addr <= rom_address;
        pend_tag  <= rom_req;
      end

      // Invalidate overrides any hit-register load in the same cycle.
      if (inval) begin
        hit_valid  <= 1'b0;
        inval_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tc0100scn_rom_bridge.sv
// tb_tc0100scn_rom_bridge
// Directed bench for the TC0100SCN ROM bridge. The bench plays the SDRAM
// arbiter by hand and checks ack, data, SDRAM address, request count and
// overrun against hand-computed values.
module tb_tc0100scn_rom_bridge;

  localparam logic [26:0] BASE = 27'h0400000;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] rom_address;
  logic        rom_req;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic [26:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic        inval;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int req_count = 0;
  logic mem_req_q = 1'b0;
  logic [26:0] seen_addr;

  tc0100scn_rom_bridge #(
    .ROM_BASE (BASE),
    .HIT_EN   (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rom_address (rom_address),
    .rom_req     (rom_req),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_valid   (mem_valid),
    .mem_data    (mem_data),
    .inval       (inval),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Count SDRAM requests issued (rising edges of mem_req).
  always @(negedge clk) begin
    if (mem_req && !mem_req_q) req_count++;
    mem_req_q = mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait, bounded, for mem_req and record the requested address.
  task automatic wait_mem_req(input string tag);
    for (int i = 0; i < 20 && !mem_req; i++) tick();
    check(tag, {31'b0, mem_req}, 32'd1);
    seen_addr = mem_addr;
  endtask

  // Accept the request, then return two beats.
  task automatic ack_and_beats(input logic [15:0] hi, input logic [15:0] lo);
    mem_ack = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_valid = 1'b1;
    mem_data  = hi;
    tick();
    mem_data  = lo;
    tick();
    mem_valid = 1'b0;
    mem_data  = 16'h0;
  endtask

  initial begin
    reset = 1'b1;
    rom_address = '0;
    rom_req = 1'b0;
    mem_ack = 1'b0;
    mem_valid = 1'b0;
    mem_data = '0;
    inval = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("reset rom_ack",  {31'b0, rom_ack}, 32'd0);
    check("reset rom_data", rom_data, 32'h0);
    check("reset mem_req",  {31'b0, mem_req}, 32'd0);
    check("reset mem_addr", {5'b0, mem_addr}, 32'h0);
    check("reset overrun",  {31'b0, overrun}, 32'd0);

    // First miss: addr 0x104, mem_ack after 2 cycles
    rom_address = 21'h000104;
    rom_req = 1'b1;
    wait_mem_req("t1 mem_req");
    check("t1 mem_addr", {5'b0, seen_addr}, 32'h0400104);
    tick();
    tick();
    check("t1 ack pending", {31'b0, rom_ack}, 32'd0);
    ack_and_beats(16'hABCD, 16'h1234);
    check("t1 rom_ack",  {31'b0, rom_ack}, 32'd1);
    check("t1 rom_data", rom_data, 32'hABCD1234);
    check("t1 req_count", req_count, 32'd1);

    // Same address again: hit, acked one cycle later, no SDRAM request
    rom_req = 1'b0;
    tick();
    check("t2 hit rom_ack",  {31'b0, rom_ack}, 32'd0);
    check("t2 hit rom_data", rom_data, 32'hABCD1234);
    check("t2 hit mem_req",  {31'b0, mem_req}, 32'd0);
    tick();
    tick();
    check("t2 req_count", req_count, 32'd1);

    // Invalidate, then same address: full fetch
    inval = 1'b1;
    tick();
    inval = 1'b0;
    rom_req = 1'b1;
    wait_mem_req("t3 mem_req");
    check("t3 mem_addr", {5'b0, seen_addr}, 32'h0400104);
    ack_and_beats(16'h5555, 16'hAAAA);
    check("t3 rom_ack",  {31'b0, rom_ack}, 32'd1);
    check("t3 rom_data", rom_data, 32'h5555AAAA);
    check("t3 req_count", req_count, 32'd2);

    // Two toggles 4 cycles apart during a miss
    rom_address = 21'h000200;
    rom_req = 1'b0;
    wait_mem_req("t4a mem_req");
    check("t4a mem_addr", {5'b0, seen_addr}, 32'h0400200);
    tick();
    tick();
    tick();
    rom_address = 21'h000300;
    rom_req = 1'b1;
    tick();
    ack_and_beats(16'h0102, 16'h0304);
    check("t4a rom_ack",  {31'b0, rom_ack}, 32'd0);
    check("t4a rom_data", rom_data, 32'h01020304);
    wait_mem_req("t4b mem_req");
    check("t4b mem_addr", {5'b0, seen_addr}, 32'h0400300);
    ack_and_beats(16'h0506, 16'h0708);
    check("t4b rom_ack",  {31'b0, rom_ack}, 32'd1);
    check("t4b rom_data", rom_data, 32'h05060708);
    check("t4 overrun",   {31'b0, overrun}, 32'd0);
    check("t4 req_count", req_count, 32'd4);

    // Three toggles during one miss: middle one is lost
    rom_address = 21'h000400;
    rom_req = 1'b0;
    tick();
    rom_address = 21'h000500;
    rom_req = 1'b1;
    tick();
    rom_address = 21'h000600;
    rom_req = 1'b0;
    tick();
    wait_mem_req("t5a mem_req");
    check("t5a mem_addr", {5'b0, seen_addr}, 32'h0400400);
    ack_and_beats(16'h1111, 16'h2222);
    check("t5a rom_data", rom_data, 32'h11112222);
    wait_mem_req("t5b mem_req");
    check("t5b mem_addr", {5'b0, seen_addr}, 32'h0400600);
    ack_and_beats(16'h3333, 16'h4444);
    check("t5 overrun",   {31'b0, overrun}, 32'd1);
    check("t5 rom_ack",   {31'b0, rom_ack}, {31'b0, rom_req});
    check("t5 rom_data",  rom_data, 32'h33334444);
    check("t5 req_count", req_count, 32'd6);

    // Reset during BEAT0, then stray beats
    rom_address = 21'h000700;
    rom_req = 1'b1;
    wait_mem_req("t6 mem_req");
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    reset = 1'b1;
    rom_req = 1'b0;
    tick();
    reset = 1'b0;
    mem_valid = 1'b1;
    mem_data = 16'hDEAD;
    tick();
    mem_data = 16'hBEEF;
    tick();
    mem_valid = 1'b0;
    tick();
    check("t6 rom_ack",  {31'b0, rom_ack}, 32'd0);
    check("t6 rom_data", rom_data, 32'h0);
    check("t6 mem_req",  {31'b0, mem_req}, 32'd0);
    check("t6 overrun",  {31'b0, overrun}, 32'd0);

    // Bridge is idle with an empty hit register: the old address misses
    rom_address = 21'h000104;
    rom_req = 1'b1;
    wait_mem_req("t7 mem_req");
    check("t7 mem_addr", {5'b0, seen_addr}, 32'h0400104);
    ack_and_beats(16'hCAFE, 16'hF00D);
    check("t7 rom_ack",  {31'b0, rom_ack}, 32'd1);
    check("t7 rom_data", rom_data, 32'hCAFEF00D);
    check("t7 req_count", req_count, 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
